// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage constants and state encoding
package mips_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int WORD_BYTES = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DISCARD,
        ST_HOLD
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register slice with enable and bubble clear
module ifid_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Clear beats enable so a redirect can bubble the stage even while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= CLR_VAL;
        end else if (clr_i) begin
            data_q <= CLR_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - MIPS instruction fetch stage with skid buffer and branch redirect
module ifetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pcsrc_MEM,
    input  logic [WIDTH-1:0] pcbranch_MEM,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_DEC,
    output logic [WIDTH-1:0] pcplus4_DEC,
    output logic             valid_DEC,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic             squash
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [WIDTH-1:0] skid_pc4_q, skid_pc4_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_tgt;
    logic             ifid_clr;
    logic [WIDTH-1:0] ifid_instr_d;
    logic [WIDTH-1:0] ifid_pc4_d;
    logic             ifid_valid_q;

    assign pc_plus4   = pc_q + WIDTH'(WORD_BYTES);
    assign branch_tgt = pcbranch_MEM & ~WIDTH'(WORD_BYTES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            target_q     <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    // When decode is free but nothing arrives, IF/ID takes a bubble so an old
    // instruction is never presented twice.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        imem_req     = 1'b0;
        ifid_clr     = ~stall;
        ifid_instr_d = imem_rdata;
        ifid_pc4_d   = pc_plus4;
        squash       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (!stall) begin
                        ifid_clr = 1'b0;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    ifid_clr     = 1'b0;
                    ifid_instr_d = skid_instr_q;
                    ifid_pc4_d   = skid_pc4_q;
                    state_d      = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    pc_d    = target_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // An unanswered request must stay on its old address, so the target waits.
        if (pcsrc_MEM) begin
            squash       = 1'b1;
            ifid_clr     = 1'b1;
            skid_instr_d = '0;
            skid_pc4_d   = '0;
            if (imem_req && !imem_ready) begin
                pc_d     = pc_q;
                target_d = branch_tgt;
                state_d  = ST_DISCARD;
            end else begin
                pc_d    = branch_tgt;
                state_d = ST_FETCH;
            end
        end
    end

    ifid_reg #(.WIDTH(WIDTH), .CLR_VAL(WIDTH'(NOP_INSTR))) u_ifid_instr (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (~stall),
        .clr_i  (ifid_clr),
        .d_i    (ifid_instr_d),
        .q_o    (instr_DEC)
    );

    ifid_reg #(.WIDTH(WIDTH), .CLR_VAL('0)) u_ifid_pc4 (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (~stall),
        .clr_i  (ifid_clr),
        .d_i    (ifid_pc4_d),
        .q_o    (pcplus4_DEC)
    );

    ifid_reg #(.WIDTH(1), .CLR_VAL(1'b0)) u_ifid_valid (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (~stall),
        .clr_i  (ifid_clr),
        .d_i    (1'b1),
        .q_o    (ifid_valid_q)
    );

    assign valid_DEC = ifid_valid_q;
    assign imem_addr = pc_q;
    assign opcode    = instr_DEC[OPCODE_MSB:OPCODE_LSB];
    assign funct     = instr_DEC[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed and random checks of ifetch_unit against a behavioural model
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pcsrc_MEM;
    logic [31:0] pcbranch_MEM;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_DEC;
    logic [31:0] pcplus4_DEC;
    logic        valid_DEC;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        squash;

    int n_checks = 0;
    int n_errors = 0;

    // model: fetch pointer, boot flag, pending redirect, held instruction, IF/ID
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_drop;
    logic [31:0] m_tgt;
    logic [31:0] m_skid_instr[$];
    logic [31:0] m_skid_pc4[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    always #5 clk = ~clk;

    ifetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pcsrc_MEM    (pcsrc_MEM),
        .pcbranch_MEM (pcbranch_MEM),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_DEC    (instr_DEC),
        .pcplus4_DEC  (pcplus4_DEC),
        .valid_DEC    (valid_DEC),
        .opcode       (opcode),
        .funct        (funct),
        .squash       (squash)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8) ? 32'h2002_0005 : (a ^ 32'h8C1F_0000);
    endfunction

    function automatic bit model_req();
        return !m_boot && (m_skid_instr.size() == 0);
    endfunction

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = 32'h0;
        m_drop  = 1'b0;
        m_tgt   = 32'h0;
        m_skid_instr.delete();
        m_skid_pc4.delete();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit br, input logic [31:0] t,
                              input bit rdy, input logic [31:0] data);
        bit          req;
        logic [31:0] tal;
        req = model_req();
        tal = {t[31:2], 2'b00};
        if (br) begin
            bubble();
            m_skid_instr.delete();
            m_skid_pc4.delete();
            m_boot = 1'b0;
            if (req && !rdy) begin
                m_drop = 1'b1;
                m_tgt  = tal;
            end else begin
                m_drop = 1'b0;
                m_pc   = tal;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (!s) bubble();
        end else if (m_skid_instr.size() != 0) begin
            if (!s) begin
                m_instr = m_skid_instr.pop_front();
                m_pc4   = m_skid_pc4.pop_front();
                m_valid = 1'b1;
            end
        end else if (m_drop) begin
            if (rdy) begin
                m_drop = 1'b0;
                m_pc   = m_tgt;
            end
            if (!s) bubble();
        end else if (rdy) begin
            if (s) begin
                m_skid_instr.push_back(data);
                m_skid_pc4.push_back(m_pc + 32'd4);
            end else begin
                m_instr = data;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            bubble();
        end
    endtask

    task automatic cycle(input bit s, input bit br, input logic [31:0] t, input bit rdy);
        @(negedge clk);
        stall        = s;
        pcsrc_MEM    = br;
        pcbranch_MEM = t;
        imem_ready   = rdy;
        imem_rdata   = rdy ? mem_word(m_pc) : $urandom;
        #1;
        chk("imem_req", {31'b0, imem_req}, {31'b0, model_req()});
        chk("imem_addr", imem_addr, m_pc);
        chk("squash", {31'b0, squash}, {31'b0, br});
        model_step(s, br, t, rdy, imem_rdata);
        @(posedge clk);
        #1;
        chk("instr_DEC", instr_DEC, m_instr);
        chk("pcplus4_DEC", pcplus4_DEC, m_pc4);
        chk("valid_DEC", {31'b0, valid_DEC}, {31'b0, m_valid});
        chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
        chk("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr_DEC, 32'h0);
        chk({tag, "_pc4"}, pcplus4_DEC, 32'h0);
        chk({tag, "_valid"}, {31'b0, valid_DEC}, 32'h0);
        chk({tag, "_squash"}, {31'b0, squash}, 32'h0);
    endtask

    initial begin
        reset        = 1'b0;
        stall        = 1'b0;
        pcsrc_MEM    = 1'b0;
        pcbranch_MEM = 32'h0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("por");
        @(posedge clk);
        #2 reset = 1'b1;

        // streaming fetch from RESET_PC
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        // stall while addr 8 returns, then release from the skid buffer
        cycle(1, 0, 32'h0, 1);
        cycle(1, 0, 32'h0, 1);
        cycle(1, 0, 32'h0, 1);
        chk("stall_keeps_pc4", pcplus4_DEC, 32'h8);
        cycle(0, 0, 32'h0, 1);
        chk("skid_instr", instr_DEC, 32'h2002_0005);
        chk("skid_pc4", pcplus4_DEC, 32'hC);
        cycle(0, 0, 32'h0, 1);
        // redirect with ready in the same cycle
        cycle(0, 1, 32'h40, 1);
        chk("redir_bubble", {31'b0, valid_DEC}, 32'h0);
        chk("redir_addr", imem_addr, 32'h40);
        cycle(0, 0, 32'h0, 1);
        // redirect while the request is unanswered: old address held, data dropped
        cycle(0, 1, 32'h83, 0);
        chk("discard_addr_held", imem_addr, 32'h44);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 1);
        chk("discard_dropped", {31'b0, valid_DEC}, 32'h0);
        chk("discard_target", imem_addr, 32'h80);
        cycle(0, 0, 32'h0, 1);
        // redirect and stall together
        cycle(1, 1, 32'h100, 1);
        chk("stall_redir_addr", imem_addr, 32'h100);
        // address wrap at the top of the space
        cycle(0, 1, 32'hFFFF_FFFE, 1);
        cycle(0, 0, 32'h0, 1);
        chk("wrap_pc4", pcplus4_DEC, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 0);
        chk("pre_reset_addr", imem_addr, 32'h18);

        // asynchronous reset mid-request
        @(negedge clk);
        imem_ready = 1'b0;
        reset      = 1'b0;
        #1;
        chk_reset_values("mid");
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0, 1);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom, $urandom_range(0, 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
